// File: rtl/ddr3_read_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_read_arbiter
//
// Round-robin scheduler that lets NUM_CH read requesters share one DDR3 DMA
// read engine. Each requester holds a request together with its start address
// and beat count. The arbiter grants one channel at a time and issues one read
// command to the engine. It keeps the grant until the engine reports
// end-of-packet, then pulses ack to the winning channel for one cycle.
//
// Ports
//   clk         single clock for the whole block
//   rst         asynchronous, active-high reset
//   req         per-channel level request, held until the matching ack
//   start_addr  packed start addresses, channel i at [i*W +: W]
//   length      packed beat counts, channel i at [i*W +: W]
//   ack         one-cycle done pulse to the granted channel
//   cmd_valid   read command valid to the DMA engine
//   cmd_ready   engine accepts the command when high together with cmd_valid
//   cmd_addr    latched start address of the granted channel
//   cmd_length  latched beat count of the granted channel
//   cmd_ch      granted channel index, used to steer read data downstream
//   rd_eop      engine end-of-packet (dout_eop qualified by dout_rdy)
//   busy        high in any state other than IDLE
//   err         sticky watchdog flag, set when WAIT lasts TIMEOUT cycles
//
// All outputs are registered, so there is no combinational path from any
// input to any output.
// ---------------------------------------------------------------------------
module ddr3_read_arbiter #(
   parameter int NUM_CH         = 16,
   parameter int CH_W           = 4,
   parameter int DMA_ADDR_WIDTH = 27,
   parameter int TIMEOUT        = 65535
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                req,
   input  logic [NUM_CH*DMA_ADDR_WIDTH-1:0] start_addr,
   input  logic [NUM_CH*DMA_ADDR_WIDTH-1:0] length,
   output logic [NUM_CH-1:0]                ack,
   output logic                             cmd_valid,
   input  logic                             cmd_ready,
   output logic [DMA_ADDR_WIDTH-1:0]        cmd_addr,
   output logic [DMA_ADDR_WIDTH-1:0]        cmd_length,
   output logic [CH_W-1:0]                  cmd_ch,
   input  logic                             rd_eop,
   output logic                             busy,
   output logic                             err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic [31:0]     TIMEOUT_W = 32'(TIMEOUT);
   localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

   state_t                    state;
   logic [CH_W-1:0]           ptr;
   logic [NUM_CH-1:0]         mask;
   logic [31:0]               wd_cnt;

   logic [NUM_CH-1:0]         eligible;
   logic                      any_eligible;
   logic [CH_W-1:0]           pick;
   logic [DMA_ADDR_WIDTH-1:0] pick_addr;
   logic [DMA_ADDR_WIDTH-1:0] pick_len;
   logic [CH_W-1:0]           next_ptr;

   // One-hot vector with only bit ch set.
   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
      logic [NUM_CH-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // First set bit of elig, searching upward from base with wrap-around.
   // The sum is one bit wider than the index, so base + offset cannot
   // overflow before the modulo-NUM_CH correction is applied.
   function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                               input logic [CH_W-1:0]   base);
      logic [CH_W:0]   s;
      logic [CH_W-1:0] idx;
      logic [CH_W-1:0] sel;
      logic            found;
      sel   = base;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         s = {1'b0, base} + (CH_W+1)'(i);
         if (s >= (CH_W+1)'(NUM_CH)) begin
            s = s - (CH_W+1)'(NUM_CH);
         end
         idx = s[CH_W-1:0];
         if (!found && elig[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // Candidate selection. mask only blocks the channel acked in the
   // previous cycle, so a requester that keeps req high gets served again
   // but only after every other pending channel.
   always_comb begin
      eligible     = req & ~mask;
      any_eligible = |eligible;
      pick         = rr_pick(eligible, ptr);
      pick_addr    = '0;
      pick_len     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick == CH_W'(i)) begin
            pick_addr = start_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
            pick_len  = length[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
         end
      end
      next_ptr = (cmd_ch == LAST_CH) ? '0 : cmd_ch + CH_W'(1);
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         mask       <= '0;
         wd_cnt     <= '0;
         ack        <= '0;
         cmd_valid  <= 1'b0;
         cmd_addr   <= '0;
         cmd_length <= '0;
         cmd_ch     <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mask <= '0;
               if (any_eligible) begin
                  cmd_ch     <= pick;
                  cmd_addr   <= pick_addr;
                  cmd_length <= pick_len;
                  // A zero-length grant passes through ISSUE without ever
                  // presenting a command to the engine.
                  cmd_valid  <= (pick_len != '0);
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end

            ISSUE: begin
               if (cmd_length == '0) begin
                  ack   <= onehot(cmd_ch);
                  state <= ACK;
               end else if (cmd_ready) begin
                  // rd_eop in this cycle belongs to no command of ours.
                  cmd_valid <= 1'b0;
                  wd_cnt    <= '0;
                  state     <= WAIT;
               end
            end

            WAIT: begin
               if (TIMEOUT != 0 && wd_cnt != TIMEOUT_W) begin
                  wd_cnt <= wd_cnt + 32'd1;
               end
               if (TIMEOUT != 0 && (wd_cnt + 32'd1) == TIMEOUT_W) begin
                  err <= 1'b1;
               end
               if (rd_eop) begin
                  ack   <= onehot(cmd_ch);
                  state <= ACK;
               end
            end

            ACK: begin
               ack   <= '0;
               ptr   <= next_ptr;
               mask  <= onehot(cmd_ch);
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
